// File: rtl/axi_vram_pkg.sv
`default_nettype none
// ============================================================================
// Module  : axi_vram_pkg
// Brief   : Shared FSM state type and response codes for the AXI4-Lite VRAM
//           responder.
// Revision: 1.0 - initial release
// ============================================================================
package axi_vram_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WR_ISSUE   = 3'd1,
        WR_RESP    = 3'd2,
        RD_ISSUE   = 3'd3,
        RD_CAPTURE = 3'd4,
        RD_RESP    = 3'd5
    } axi_vram_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage
`default_nettype wire

// File: rtl/axi_lite_vram_responder.sv
`default_nettype none
// ============================================================================
// Module  : axi_lite_vram_responder
// Brief   : AXI4-Lite slave mapping reads/writes onto one synchronous memory
//           port. Optional macro VRAM_RANGE_CHECK_EN enables SLVERR on
//           out-of-range accesses; otherwise the word index wraps.
// Revision: 1.0 - initial release
// ============================================================================
module axi_lite_vram_responder
    import axi_vram_pkg::*;
#(
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_AXI_ADDR_WIDTH = 32,
    parameter int DEPTH            = 2048
) (
    input  logic                          axi_aclk,
    input  logic                          axi_aresetn,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   axi_awaddr,
    input  logic [2:0]                    axi_awprot,
    input  logic                          axi_awvalid,
    output logic                          axi_awready,
    input  logic [C_AXI_DATA_WIDTH-1:0]   axi_wdata,
    input  logic [C_AXI_DATA_WIDTH/8-1:0] axi_wstrb,
    input  logic                          axi_wvalid,
    output logic                          axi_wready,
    output logic [1:0]                    axi_bresp,
    output logic                          axi_bvalid,
    input  logic                          axi_bready,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   axi_araddr,
    input  logic [2:0]                    axi_arprot,
    input  logic                          axi_arvalid,
    output logic                          axi_arready,
    output logic [C_AXI_DATA_WIDTH-1:0]   axi_rdata,
    output logic [1:0]                    axi_rresp,
    output logic                          axi_rvalid,
    input  logic                          axi_rready,
    output logic                          mem_en,
    output logic [C_AXI_DATA_WIDTH/8-1:0] mem_we,
    output logic [$clog2(DEPTH)-1:0]      mem_addr,
    output logic [C_AXI_DATA_WIDTH-1:0]   mem_wdata,
    input  logic [C_AXI_DATA_WIDTH-1:0]   mem_rdata
);

    localparam int c_MEM_AW = $clog2(DEPTH);
    localparam int c_IDX_W  = C_AXI_ADDR_WIDTH - 2;
    localparam int c_STRB_W = C_AXI_DATA_WIDTH / 8;

    axi_vram_state_t               r_state;
    axi_vram_state_t               w_next;
    logic                          r_aw_hold;
    logic                          r_w_hold;
    logic [c_IDX_W-1:0]            r_awidx;
    logic [c_IDX_W-1:0]            r_aridx;
    logic [C_AXI_DATA_WIDTH-1:0]   r_wdata;
    logic [c_STRB_W-1:0]           r_wstrb;
    logic                          r_bvalid;
    logic [1:0]                    r_bresp;
    logic                          r_rvalid;
    logic [1:0]                    r_rresp;
    logic [C_AXI_DATA_WIDTH-1:0]   r_rdata;

    logic w_idle;
    logic w_aw_hs;
    logic w_w_hs;
    logic w_ar_hs;
    logic w_wr_ok;
    logic w_rd_ok;
    logic w_unused;

    // Readies are gated by reset so they read 0 while reset is asserted.
    assign w_idle      = (r_state == IDLE);
    assign axi_awready = axi_aresetn && w_idle && !r_aw_hold;
    assign axi_wready  = axi_aresetn && w_idle && !r_w_hold;
    assign axi_arready = axi_aresetn && w_idle && !r_aw_hold && !r_w_hold
                         && !axi_awvalid && !axi_wvalid;

    assign w_aw_hs = axi_awvalid && axi_awready;
    assign w_w_hs  = axi_wvalid  && axi_wready;
    assign w_ar_hs = axi_arvalid && axi_arready;

`ifdef VRAM_RANGE_CHECK_EN
    localparam logic [c_IDX_W-1:0] c_DEPTH_IDX = c_IDX_W'(DEPTH);
    assign w_wr_ok  = (r_awidx < c_DEPTH_IDX);
    assign w_rd_ok  = (r_aridx < c_DEPTH_IDX);
    assign w_unused = ^{axi_awprot, axi_arprot, axi_awaddr[1:0], axi_araddr[1:0]};
`else
    assign w_wr_ok  = 1'b1;
    assign w_rd_ok  = 1'b1;
    assign w_unused = ^{axi_awprot, axi_arprot, axi_awaddr[1:0], axi_araddr[1:0],
                        r_awidx[c_IDX_W-1:c_MEM_AW], r_aridx[c_IDX_W-1:c_MEM_AW]};
`endif

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        mem_en    = 1'b0;
        mem_we    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (r_state)
            IDLE: begin
                if ((r_aw_hold || w_aw_hs) && (r_w_hold || w_w_hs)) begin
                    w_next = WR_ISSUE;
                end else if (w_ar_hs) begin
                    w_next = RD_ISSUE;
                end
            end
            WR_ISSUE: begin
                mem_en    = 1'b1;
                mem_addr  = r_awidx[c_MEM_AW-1:0];
                mem_wdata = r_wdata;
                mem_we    = w_wr_ok ? r_wstrb : '0;
                w_next    = WR_RESP;
            end
            WR_RESP: begin
                if (axi_bready) w_next = IDLE;
            end
            RD_ISSUE: begin
                mem_en   = 1'b1;
                mem_addr = r_aridx[c_MEM_AW-1:0];
                w_next   = RD_CAPTURE;
            end
            RD_CAPTURE: begin
                w_next = RD_RESP;
            end
            RD_RESP: begin
                if (axi_rready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Each write half is latched independently; both clear once issued.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_aw_hold <= 1'b0;
            r_w_hold  <= 1'b0;
            r_awidx   <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_aridx   <= '0;
        end else begin
            if (r_state == WR_ISSUE) begin
                r_aw_hold <= 1'b0;
                r_w_hold  <= 1'b0;
            end else begin
                if (w_aw_hs) begin
                    r_aw_hold <= 1'b1;
                    r_awidx   <= axi_awaddr[C_AXI_ADDR_WIDTH-1:2];
                end
                if (w_w_hs) begin
                    r_w_hold <= 1'b1;
                    r_wdata  <= axi_wdata;
                    r_wstrb  <= axi_wstrb;
                end
            end
            if (w_ar_hs) r_aridx <= axi_araddr[C_AXI_ADDR_WIDTH-1:2];
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_bvalid <= 1'b0;
            r_bresp  <= RESP_OKAY;
            r_rvalid <= 1'b0;
            r_rresp  <= RESP_OKAY;
            r_rdata  <= '0;
        end else begin
            if (r_state == WR_ISSUE) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
            end else if ((r_state == WR_RESP) && axi_bready) begin
                r_bvalid <= 1'b0;
            end
            if (r_state == RD_CAPTURE) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_ok ? mem_rdata : '0;
                r_rresp  <= w_rd_ok ? RESP_OKAY : RESP_SLVERR;
            end else if ((r_state == RD_RESP) && axi_rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    assign axi_bvalid = r_bvalid;
    assign axi_bresp  = r_bresp;
    assign axi_rvalid = r_rvalid;
    assign axi_rresp  = r_rresp;
    assign axi_rdata  = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_vram_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_axi_lite_vram_responder
// Brief   : Scoreboard bench for axi_lite_vram_responder with a behavioural
//           block RAM; honours VRAM_RANGE_CHECK_EN for expected responses.
// Revision: 1.0 - initial release
// ============================================================================
module tb_axi_lite_vram_responder;

    localparam int DEPTH = 2048;
    localparam int LIM   = 50;

    logic        clk;
    logic        aresetn;
    logic [31:0] awaddr, wdata, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, wvalid, arvalid, bready, rready;
    logic [3:0]  wstrb;
    logic        axi_awready, axi_wready, axi_arready;
    logic [1:0]  axi_bresp, axi_rresp;
    logic        axi_bvalid, axi_rvalid;
    logic [31:0] axi_rdata;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [10:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    axi_lite_vram_responder #(
        .C_AXI_DATA_WIDTH(32), .C_AXI_ADDR_WIDTH(32), .DEPTH(DEPTH)
    ) dut (
        .axi_aclk(clk), .axi_aresetn(aresetn),
        .axi_awaddr(awaddr), .axi_awprot(awprot), .axi_awvalid(awvalid), .axi_awready(axi_awready),
        .axi_wdata(wdata), .axi_wstrb(wstrb), .axi_wvalid(wvalid), .axi_wready(axi_wready),
        .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(bready),
        .axi_araddr(araddr), .axi_arprot(arprot), .axi_arvalid(arvalid), .axi_arready(axi_arready),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid), .axi_rready(rready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port RAM with one-cycle read latency.
    logic [31:0] ram [DEPTH];
    always @(posedge clk) begin
        if (mem_en) begin
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            mem_rdata <= ram[mem_addr];
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference memory contents and response model.
    logic [31:0] exp_mem [DEPTH];

    task automatic model_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp);
        int unsigned idx;
        idx  = a >> 2;
        resp = 2'b00;
`ifdef VRAM_RANGE_CHECK_EN
        if (idx >= DEPTH) begin
            resp = 2'b10;
            return;
        end
`endif
        idx = idx % DEPTH;
        for (int b = 0; b < 4; b++)
            if (s[b]) exp_mem[idx][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic model_rd(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        int unsigned idx;
        idx  = a >> 2;
        resp = 2'b00;
`ifdef VRAM_RANGE_CHECK_EN
        if (idx >= DEPTH) begin
            resp = 2'b10;
            d    = 32'h0;
            return;
        end
`endif
        d = exp_mem[idx % DEPTH];
    endtask

    logic [1:0]  sb_b [$];
    logic [33:0] sb_r [$];
    int          b_pops = 0;
    logic [1:0]  eb;
    logic [33:0] er;

    always @(negedge clk) begin
        if (axi_bvalid && bready) begin
            if (sb_b.size() == 0) check("b_unexpected", axi_bvalid, 0);
            else begin
                eb = sb_b.pop_front();
                check("bresp", axi_bresp, eb);
                b_pops++;
            end
        end
        if (axi_rvalid && rready) begin
            if (sb_r.size() == 0) check("r_unexpected", axi_rvalid, 0);
            else begin
                er = sb_r.pop_front();
                check("rdata", axi_rdata, er[31:0]);
                check("rresp", axi_rresp, er[33:32]);
            end
        end
    end

    int last_aw_c, last_w_c;

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input int aw_dly, input int w_dly,
                      output logic [3:0] we_n1, output int lat);
        logic [1:0] r;
        logic awd, wd, aw_hs, w_hs;
        int c;
        model_wr(a, d, s, r);
        sb_b.push_back(r);
        awd = 0; wd = 0; c = 0; last_aw_c = -1; last_w_c = -1;
        @(posedge clk); #1;
        while (!(awd && wd) && c < LIM) begin
            if (!awd && c >= aw_dly) begin awvalid = 1; awaddr = a; end
            if (!wd && c >= w_dly) begin wvalid = 1; wdata = d; wstrb = s; end
            @(negedge clk);
            aw_hs = awvalid && axi_awready;
            w_hs  = wvalid && axi_wready;
            @(posedge clk); #1;
            if (aw_hs) begin awvalid = 0; awd = 1; last_aw_c = c; end
            if (w_hs)  begin wvalid = 0;  wd = 1;  last_w_c = c;  end
            c++;
        end
        check("wr_accept", {awd, wd}, 2'b11);
        awvalid = 0; wvalid = 0;
        we_n1 = 4'h0; lat = -1;
        for (int k = 0; k < LIM; k++) begin
            @(negedge clk);
            if (k == 0) we_n1 = mem_we;
            if (axi_bvalid) begin lat = k; break; end
        end
        check("wr_bvalid_seen", axi_bvalid, 1);
        if (bready) begin @(posedge clk); #1; end
    endtask

    task automatic wait_rvalid(output logic en1, output int lat);
        en1 = 0; lat = -1;
        for (int k = 0; k < LIM; k++) begin
            @(negedge clk);
            if (k == 0) en1 = mem_en;
            if (axi_rvalid) begin lat = k; break; end
        end
        check("rd_rvalid_seen", axi_rvalid, 1);
        if (rready) begin @(posedge clk); #1; end
    endtask

    task automatic rd(input logic [31:0] a, output logic en1, output int lat);
        logic [31:0] d;
        logic [1:0] r;
        logic hs;
        int c;
        model_rd(a, d, r);
        sb_r.push_back({r, d});
        @(posedge clk); #1;
        arvalid = 1; araddr = a; hs = 0; c = 0;
        while (!hs && c < LIM) begin
            @(negedge clk);
            hs = axi_arready;
            @(posedge clk); #1;
            c++;
        end
        arvalid = 0;
        check("rd_accept", hs, 1);
        wait_rvalid(en1, lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    logic [3:0]  we1;
    logic        en1, hs, any_rdy, all_bv;
    int          lat, bp0, bpa, c;
    logic [1:0]  rr;
    logic [31:0] dd;

    initial begin
        aresetn = 0; awaddr = 0; wdata = 0; araddr = 0; awprot = 0; arprot = 0;
        awvalid = 0; wvalid = 0; arvalid = 0; wstrb = 0; bready = 1; rready = 1;
        for (int i = 0; i < DEPTH; i++) begin ram[i] = 32'h0; exp_mem[i] = 32'h0; end

        @(negedge clk);
        check("rst_ctrl", {axi_awready, axi_wready, axi_arready, axi_bvalid, axi_rvalid,
                           axi_bresp, axi_rresp, mem_en, mem_we}, 0);
        check("rst_rdata", axi_rdata, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        @(posedge clk); #1; aresetn = 1;
        @(negedge clk);
        check("rdy_after_rst", {axi_awready, axi_wready, axi_arready}, 3'b111);

        // AW and W together, then read back.
        wr(32'h0, 32'h2222_2222, 4'hF, 0, 0, we1, lat);
        check("t1_we_n1", we1, 4'hF);
        check("t1_b_lat", lat, 1);
        rd(32'h0, en1, lat);
        check("t1_en_n1", en1, 1);
        check("t1_r_lat", lat, 2);
        wr(32'h4, 32'h4444_4444, 4'hF, 0, 0, we1, lat);

        // W leads AW by 5 cycles, partial strobe.
        wr(32'h10, 32'h2222_2222, 4'hF, 0, 0, we1, lat);
        wr(32'h10, 32'hA5A5_A5A5, 4'h3, 5, 0, we1, lat);
        check("wfirst_w_c", last_w_c, 0);
        check("wfirst_aw_c", last_aw_c, 5);
        check("wfirst_we_n1", we1, 4'h3);
        check("wfirst_b_lat", lat, 1);
        rd(32'h10, en1, lat);

        // AW leads W by 3 cycles.
        wr(32'hC, 32'h1234_5678, 4'hC, 0, 3, we1, lat);
        check("awfirst_we_n1", we1, 4'hC);
        check("awfirst_b_lat", lat, 1);
        rd(32'hC, en1, lat);

        // Response back-pressure.
        bready = 0; bp0 = b_pops;
        wr(32'h14, 32'h55AA_55AA, 4'hF, 0, 0, we1, lat);
        any_rdy = 0; all_bv = 1;
        repeat (10) begin
            @(negedge clk);
            any_rdy = any_rdy | axi_awready | axi_wready | axi_arready;
            all_bv  = all_bv & axi_bvalid;
        end
        check("stall_bvalid", all_bv, 1);
        check("stall_no_ready", any_rdy, 0);
        @(posedge clk); #1; bready = 1;
        @(posedge clk); #1;
        check("stall_b_count", b_pops - bp0, 1);
        @(negedge clk);
        check("stall_ready_back", axi_awready, 1);
        rd(32'h14, en1, lat);

        // Simultaneous read and write: write first.
        model_wr(32'h8, 32'h1111_1111, 4'hF, rr); sb_b.push_back(rr);
        model_rd(32'h4, dd, rr); sb_r.push_back({rr, dd});
        bp0 = b_pops; bpa = b_pops;
        @(posedge clk); #1;
        arvalid = 1; araddr = 32'h4;
        awvalid = 1; awaddr = 32'h8; wvalid = 1; wdata = 32'h1111_1111; wstrb = 4'hF;
        @(negedge clk);
        check("sim_ar_blocked", axi_arready, 0);
        check("sim_wr_taken", {axi_awready, axi_wready}, 2'b11);
        @(posedge clk); #1; awvalid = 0; wvalid = 0;
        hs = 0; c = 0;
        while (!hs && c < LIM) begin
            @(negedge clk);
            if (axi_arready) begin hs = 1; bpa = b_pops; end
            @(posedge clk); #1;
            c++;
        end
        arvalid = 0;
        check("sim_ar_acc", hs, 1);
        check("sim_rd_after_b", bpa - bp0, 1);
        wait_rvalid(en1, lat);
        rd(32'h8, en1, lat);

        // Out-of-range access at word 2048.
        wr(32'h2000, 32'h9999_9999, 4'hF, 0, 0, we1, lat);
`ifdef VRAM_RANGE_CHECK_EN
        check("oor_we_n1", we1, 4'h0);
`else
        check("oor_we_n1", we1, 4'hF);
`endif
        rd(32'h0, en1, lat);
        rd(32'h2000, en1, lat);

        // Zero strobe write completes with no data change.
        wr(32'h4, 32'hDEAD_BEEF, 4'h0, 0, 0, we1, lat);
        check("zstrb_we_n1", we1, 4'h0);
        check("zstrb_b_lat", lat, 1);
        rd(32'h4, en1, lat);

        // Reset during RD_CAPTURE.
        @(posedge clk); #1; arvalid = 1; araddr = 32'h0;
        @(negedge clk);
        check("rst_ar_acc", axi_arready, 1);
        @(posedge clk); #1; arvalid = 0;
        @(posedge clk); #1;
        aresetn = 0;
        #1;
        check("rstmid_now", {axi_rvalid, axi_awready, axi_arready, mem_en}, 0);
        @(posedge clk); #1;
        check("rstmid_rvalid_n3", axi_rvalid, 0);
        @(posedge clk); #1; aresetn = 1;
        rd(32'h0, en1, lat);
        check("rstmid_r_lat", lat, 2);

        repeat (3) @(negedge clk);
        check("sb_b_left", sb_b.size(), 0);
        check("sb_r_left", sb_r.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
